matrix_stream_writer: RTL and testbench
=======================================

MATRIX_STREAM_WRITER -- requirements
Module: matrix_stream_writer

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning matrix row count (>=1).
REQ-002 SHALL have parameter COLS, default 8, meaning matrix column count (>=1).
REQ-003 SHALL have parameter DW, default 32, meaning element data width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin one matrix; honoured only in IDLE or DONE.
REQ-007 SHALL have port col_major  input  1  traversal order, sampled when start is accepted (0 = row-major, 1 = column-major).
REQ-008 SHALL have port in_data  input  DW  element value from the producer.
REQ-009 SHALL have port in_valid  input  1  in_data is valid.
REQ-010 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-011 SHALL have port out_data  output  DW  registered element.
REQ-012 SHALL have port out_row / out_col  output  RW / CW  indices of out_data; RW = max(1,$clog2(ROWS)), CW = max(1,$clog2(COLS)).
REQ-013 SHALL have port out_valid, out_ready  output / input  1  downstream handshake.
REQ-014 SHALL have port out_line_last  output  1  out_data ends a row (row-major) or a column (column-major).
REQ-015 SHALL have port out_last  output  1  out_data is the final element of the matrix.
REQ-016 SHALL have port done  output  1  level; matrix fully delivered.

Function
REQ-017 SHALL implement the states IDLE, WRITE, DRAIN and DONE.
REQ-018 SHALL move from IDLE/DONE to WRITE on start: clear indices, clear done, latch col_major.
REQ-019 SHALL use transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-020 SHALL drive in_ready = (state==WRITE) & (!out_valid | out_ready), giving zero-bubble throughput of one element per cycle.
REQ-021 SHALL, on an input transfer, load out_data/out_row/out_col/flags on the next edge with out_valid=1, giving 1-cycle latency.
REQ-022 SHALL hold out_data, indices and flags stable while out_valid & !out_ready.
REQ-023 SHALL advance the index on each input transfer: row-major increments col first and wraps COLS-1 -> 0 with row+1; column-major increments row first and wraps ROWS-1 -> 0 with col+1.
REQ-024 SHALL, on the input transfer of element (ROWS-1, COLS-1), go WRITE -> DRAIN with in_ready=0 thereafter.
REQ-025 SHALL go DRAIN -> DONE on the output transfer with out_last=1, setting done=1 in the same edge.
REQ-026 SHALL hold done=1 in DONE until the next start or rst.
REQ-027 SHALL ignore start in WRITE and DRAIN, with no effect on indices or mode.
REQ-028 SHALL handle ROWS=1 or COLS=1 with out_line_last asserted on every element of the single-length dimension; ROWS=COLS=1 SHALL give out_last on the first element.
REQ-029 SHALL clear out_valid on an output transfer with no simultaneous input transfer.

Reset
REQ-030 SHALL, on rst=1 at a clock edge: state=IDLE, out_valid=0, out_last=0, out_line_last=0, done=0, in_ready=0, indices=0, out_data=0, mode=row-major.
REQ-031 SHALL abandon a matrix when rst is asserted mid-matrix; no partial out_last and no done.

Configuration
REQ-032 SHALL, with MATRIX_STREAM_WRITER_CHECKSUM_EN defined, add output checksum [DW] = XOR of all accepted elements of the current matrix, cleared on start/rst and valid when done=1.
REQ-033 SHALL, without MATRIX_STREAM_WRITER_CHECKSUM_EN, have no checksum port and no checksum logic.

Structure
REQ-034 SHALL place the state enum and the index-width function (max(1,$clog2(n))) in shared package matrix_pkg.
REQ-035 SHALL implement the two-dimensional wrap counter as sub-module matrix_index_counter (inputs step, clear, col_major; outputs row, col, line_last, last).

Verification
REQ-036 SHALL cover: ROWS=2, COLS=3, row-major, continuous valid/ready, data 1..6 -> out (r,c) = (0,0)..(1,2), out_line_last on 3 and 6, out_last on 6, done one cycle after.
REQ-037 SHALL cover: same with col_major=1 -> order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2), out_line_last on every 2nd element.
REQ-038 SHALL cover: out_ready low for 4 cycles mid-stream -> in_ready low, out_data held, no element lost or duplicated.
REQ-039 SHALL cover: start pulsed during WRITE -> ignored; rst at element 4 of 6 -> IDLE, out_valid=0, done=0; a new start then restarts at (0,0).
REQ-040 SHALL cover: ROWS=COLS=1, data 0xA5 -> single output with out_line_last=1, out_last=1; with checksum enabled, data 0x0F,0xF0,0x33,0x3C (2x2) -> checksum 0xF0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream writer and its index counter.
package matrix_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Index width that stays legal for a single-entry dimension.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Two-dimensional (row, col) wrap counter; traversal order selected by col_major.
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   localparam int RW   = idx_width(ROWS),
   localparam int CW   = idx_width(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          clear,
   input  logic          col_major,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          line_last,
   output logic          last
);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          row_end;
   logic          col_end;

   assign row_end = (row_q == RW'(ROWS - 1));
   assign col_end = (col_q == CW'(COLS - 1));

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (step) begin
         if (col_major) begin
            if (row_end) begin
               row_d = '0;
               col_d = col_end ? '0 : col_q + CW'(1);
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            if (col_end) begin
               col_d = '0;
               row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row       = row_q;
   assign col       = col_q;
   assign line_last = col_major ? row_end : col_end;
   assign last      = row_end & col_end;

endmodule

// File: rtl/matrix_stream_writer.sv
// Streams one ROWSxCOLS matrix through a registered valid/ready stage, tagging indices.
// Optional XOR checksum output enabled by defining MATRIX_STREAM_WRITER_CHECKSUM_EN.
module matrix_stream_writer
   import matrix_pkg::*;
#(
   parameter  int ROWS = 8,
   parameter  int COLS = 8,
   parameter  int DW   = 32,
   localparam int RW   = idx_width(ROWS),
   localparam int CW   = idx_width(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          col_major,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_line_last,
   output logic          out_last,
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
   output logic [DW-1:0] checksum,
`endif
   output logic          done
);

   state_e        state_q, state_d;
   logic          mode_q, mode_d;
   logic          done_q, done_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          out_valid_q, out_valid_d;
   logic          out_line_last_q, out_line_last_d;
   logic          out_last_q, out_last_d;

   logic          in_xfer;
   logic          out_xfer;
   logic          start_ok;
   logic [RW-1:0] idx_row;
   logic [CW-1:0] idx_col;
   logic          idx_line_last;
   logic          idx_last;

   assign in_ready = (state_q == ST_WRITE) & (~out_valid_q | out_ready);
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid_q & out_ready;
   assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   matrix_index_counter #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_index (
      .clk       (clk),
      .rst       (rst),
      .step      (in_xfer),
      .clear     (start_ok),
      .col_major (mode_q),
      .row       (idx_row),
      .col       (idx_col),
      .line_last (idx_line_last),
      .last      (idx_last)
   );

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      done_d          = done_q;
      out_data_d      = out_data_q;
      out_row_d       = out_row_q;
      out_col_d       = out_col_q;
      out_valid_d     = out_valid_q;
      out_line_last_d = out_line_last_q;
      out_last_d      = out_last_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_WRITE;
               mode_d  = col_major;
               done_d  = 1'b0;
            end
         end
         ST_WRITE: begin
            if (in_xfer && idx_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (out_xfer && out_last_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The output stage refills in the same edge it drains, so throughput is one per cycle.
      if (in_xfer) begin
         out_data_d      = in_data;
         out_row_d       = idx_row;
         out_col_d       = idx_col;
         out_line_last_d = idx_line_last;
         out_last_d      = idx_last;
         out_valid_d     = 1'b1;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: datapath registers are reset too, because their reset value is visible on the outputs.
      if (rst) begin
         state_q         <= ST_IDLE;
         mode_q          <= 1'b0;
         done_q          <= 1'b0;
         out_data_q      <= '0;
         out_row_q       <= '0;
         out_col_q       <= '0;
         out_valid_q     <= 1'b0;
         out_line_last_q <= 1'b0;
         out_last_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         done_q          <= done_d;
         out_data_q      <= out_data_d;
         out_row_q       <= out_row_d;
         out_col_q       <= out_col_d;
         out_valid_q     <= out_valid_d;
         out_line_last_q <= out_line_last_d;
         out_last_q      <= out_last_d;
      end
   end

`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
   logic [DW-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (in_xfer) begin
         checksum_d = checksum_q ^ in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`endif

   assign out_data      = out_data_q;
   assign out_row       = out_row_q;
   assign out_col       = out_col_q;
   assign out_valid     = out_valid_q;
   assign out_line_last = out_line_last_q;
   assign out_last      = out_last_q;
   assign done          = done_q;

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Directed self-checking bench: 2x3 writer in both orders, stalls, start/rst abuse, 1x1 corner.
module tb_matrix_stream_writer;

   logic clk;
   logic rst;

   // 2x3 instance
   logic       a_start, a_col_major, a_in_valid, a_in_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [0:0] a_out_row;
   logic [1:0] a_out_col;
   logic       a_out_valid, a_out_ready, a_out_line_last, a_out_last, a_done;

   // 1x1 instance
   logic       b_start, b_col_major, b_in_valid, b_in_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [0:0] b_out_row;
   logic [0:0] b_out_col;
   logic       b_out_valid, b_out_ready, b_out_line_last, b_out_last, b_done;

`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
   logic [7:0] a_checksum, b_checksum, c_checksum;
   logic       c_start, c_col_major, c_in_valid, c_in_ready;
   logic [7:0] c_in_data, c_out_data;
   logic [0:0] c_out_row, c_out_col;
   logic       c_out_valid, c_out_ready, c_out_line_last, c_out_last, c_done;
   logic [7:0] cs_vals [4];
`endif

   int checks   = 0;
   int failures = 0;

   matrix_stream_writer #(.ROWS(2), .COLS(3), .DW(8)) dut_a (
      .clk           (clk),
      .rst           (rst),
      .start         (a_start),
      .col_major     (a_col_major),
      .in_data       (a_in_data),
      .in_valid      (a_in_valid),
      .in_ready      (a_in_ready),
      .out_data      (a_out_data),
      .out_row       (a_out_row),
      .out_col       (a_out_col),
      .out_valid     (a_out_valid),
      .out_ready     (a_out_ready),
      .out_line_last (a_out_line_last),
      .out_last      (a_out_last),
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
      .checksum      (a_checksum),
`endif
      .done          (a_done)
   );

   matrix_stream_writer #(.ROWS(1), .COLS(1), .DW(8)) dut_b (
      .clk           (clk),
      .rst           (rst),
      .start         (b_start),
      .col_major     (b_col_major),
      .in_data       (b_in_data),
      .in_valid      (b_in_valid),
      .in_ready      (b_in_ready),
      .out_data      (b_out_data),
      .out_row       (b_out_row),
      .out_col       (b_out_col),
      .out_valid     (b_out_valid),
      .out_ready     (b_out_ready),
      .out_line_last (b_out_line_last),
      .out_last      (b_out_last),
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
      .checksum      (b_checksum),
`endif
      .done          (b_done)
   );

`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
   matrix_stream_writer #(.ROWS(2), .COLS(2), .DW(8)) dut_c (
      .clk           (clk),
      .rst           (rst),
      .start         (c_start),
      .col_major     (c_col_major),
      .in_data       (c_in_data),
      .in_valid      (c_in_valid),
      .in_ready      (c_in_ready),
      .out_data      (c_out_data),
      .out_row       (c_out_row),
      .out_col       (c_out_col),
      .out_valid     (c_out_valid),
      .out_ready     (c_out_ready),
      .out_line_last (c_out_line_last),
      .out_last      (c_out_last),
      .checksum      (c_checksum),
      .done          (c_done)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One matrix through dut_a with data 1..6. stall_at/glitch_at count cycles after start;
   // abort_at > 0 asserts rst once that many inputs have been accepted.
   task automatic run_a(input bit cm, input int stall_at, input int stall_len,
                        input int glitch_at, input int abort_at);
      int k, n, cyc, er, ec;
      bit fin, fin_pending;
      k = 0; n = 0; cyc = 0; fin = 1'b0; fin_pending = 1'b0;
      @(negedge clk);
      a_start = 1'b1;
      a_col_major = cm;
      @(negedge clk);
      a_start = 1'b0;
      a_col_major = ~cm;
      check("start_done_clr", a_done, 0);
      check("start_out_valid", a_out_valid, 0);
      while (!fin && cyc < 100) begin
         if (abort_at > 0 && n == abort_at) begin
            rst = 1'b1;
            a_in_valid = 1'b0;
            a_start = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            check("abort_out_valid", a_out_valid, 0);
            check("abort_done", a_done, 0);
            check("abort_in_ready", a_in_ready, 0);
            check("abort_out_last", a_out_last, 0);
            check("abort_line_last", a_out_line_last, 0);
            check("abort_row", a_out_row, 0);
            check("abort_col", a_out_col, 0);
            check("abort_data", a_out_data, 0);
            @(negedge clk);
            check("abort_idle_done", a_done, 0);
            check("abort_idle_in_ready", a_in_ready, 0);
            return;
         end
         a_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         a_start     = (cyc == glitch_at);
         a_in_valid  = (n < 6);
         a_in_data   = 8'(n + 1);
         #1;
         if (n == 6) check("drain_in_ready", a_in_ready, 0);
         if (a_out_valid) begin
            if (cm) begin
               er = k % 2; ec = k / 2;
            end else begin
               er = k / 3; ec = k % 3;
            end
            check("out_data", a_out_data, k + 1);
            check("out_row", a_out_row, er);
            check("out_col", a_out_col, ec);
            check("out_line_last", a_out_line_last, cm ? (er == 1) : (ec == 2));
            check("out_last", a_out_last, k == 5);
            check("done_early", a_done, 0);
            if (a_out_ready) begin
               fin_pending = (k == 5);
               k++;
            end else begin
               check("stall_in_ready", a_in_ready, 0);
            end
         end
         if (a_in_valid && a_in_ready) n++;
         @(negedge clk);
         cyc++;
         if (fin_pending) begin
            check("done_set", a_done, 1);
            check("done_out_valid", a_out_valid, 0);
            check("done_in_ready", a_in_ready, 0);
            fin = 1'b1;
         end
      end
      a_start = 1'b0;
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      check("finished", fin, 1);
      check("out_count", k, 6);
      check("cycles", cyc, 7 + stall_len);
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_col_major = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_start = 1'b0; b_col_major = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
      c_start = 1'b0; c_col_major = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1;
      cs_vals = '{8'h0F, 8'hF0, 8'h33, 8'h3C};
`endif
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_done", a_done, 0);
      check("rst_in_ready", a_in_ready, 0);
      check("rst_out_data", a_out_data, 0);
      check("rst_out_last", a_out_last, 0);
      rst = 1'b0;

      // Row-major, continuous flow; done must hold in DONE.
      run_a(1'b0, -1, 0, -1, 0);
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
      check("a_checksum", a_checksum, 8'h07);
`endif
      repeat (3) @(negedge clk);
      check("done_hold", a_done, 1);
      check("done_hold_in_ready", a_in_ready, 0);

      // Column-major from DONE, with an ignored start (and flipped mode) mid-write.
      run_a(1'b1, -1, 0, 1, 0);

      // Downstream stall of 4 cycles mid-stream.
      run_a(1'b0, 2, 4, -1, 0);

      // Ignored start, then reset after 4 of 6 inputs, then a clean restart.
      run_a(1'b0, -1, 0, 1, 4);
      run_a(1'b0, -1, 0, -1, 0);

      // 1x1 matrix.
      @(negedge clk);
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      b_in_valid = 1'b1;
      b_in_data = 8'hA5;
      #1;
      check("b_in_ready", b_in_ready, 1);
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      check("b_in_ready_drain", b_in_ready, 0);
      check("b_out_valid", b_out_valid, 1);
      check("b_out_data", b_out_data, 8'hA5);
      check("b_out_row", b_out_row, 0);
      check("b_out_col", b_out_col, 0);
      check("b_line_last", b_out_line_last, 1);
      check("b_out_last", b_out_last, 1);
      check("b_done_early", b_done, 0);
      @(negedge clk);
      check("b_done", b_done, 1);
      check("b_out_valid_after", b_out_valid, 0);
`ifdef MATRIX_STREAM_WRITER_CHECKSUM_EN
      check("b_checksum", b_checksum, 8'hA5);

      // 2x2 checksum.
      @(negedge clk);
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      check("c_checksum_clr", c_checksum, 0);
      begin
         int n, cyc;
         n = 0; cyc = 0;
         while (!c_done && cyc < 20) begin
            c_in_valid = (n < 4);
            c_in_data  = (n < 4) ? cs_vals[n] : 8'h00;
            #1;
            if (c_in_valid && c_in_ready) n++;
            @(negedge clk);
            cyc++;
         end
         c_in_valid = 1'b0;
         check("c_done", c_done, 1);
         check("c_checksum", c_checksum, 8'hF0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
